// File: rtl/dvi_rx_tmds_decoder.sv
// TMDS channel decoder for the DVI receiver: registered 10b->8b decode plus a
// word-alignment FSM that requests deserializer bitslips until control-token runs appear.
module dvi_rx_tmds_decoder #(
  parameter int unsigned MIN_RUN        = 8,
  parameter int unsigned SEARCH_TIMEOUT = 4096,
  parameter int unsigned BITSLIP_WAIT   = 16,
  parameter int unsigned LOSS_TIMEOUT   = 1048576
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] in_data,
  output logic       out_bitslip,
  output logic       out_locked,
  output logic       out_de,
  output logic [1:0] out_ctl,
  output logic [7:0] out_data
);

  localparam int unsigned RunW    = $clog2(MIN_RUN + 1);
  localparam int unsigned SearchW = $clog2(SEARCH_TIMEOUT);
  localparam int unsigned WaitW   = $clog2(BITSLIP_WAIT);
  localparam int unsigned LossW   = $clog2(LOSS_TIMEOUT);
  localparam int unsigned TimerW0 = (SearchW > WaitW) ? SearchW : WaitW;
  localparam int unsigned TimerW  = (TimerW0 > LossW) ? TimerW0 : LossW;

  localparam logic [RunW-1:0]   RunMax     = RunW'(MIN_RUN);
  localparam logic [RunW-1:0]   RunLast    = RunW'(MIN_RUN - 1);
  localparam logic [TimerW-1:0] SearchLast = TimerW'(SEARCH_TIMEOUT - 1);
  localparam logic [TimerW-1:0] WaitLast   = TimerW'(BITSLIP_WAIT - 1);
  localparam logic [TimerW-1:0] LossLast   = TimerW'(LOSS_TIMEOUT - 1);

  typedef enum logic [1:0] {StSearch, StSlip, StWait, StLocked} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [RunW-1:0]   run_q, run_d;
  logic              is_token;
  logic [1:0]        token_ctl;
  logic [7:0]        q;
  logic [7:0]        data_dec;
  logic              qualify;

  // Word decode: token match and TMDS data inversion/transition recovery.
  always_comb begin
    is_token  = 1'b1;
    token_ctl = 2'b00;
    case (in_data)
      10'h354: token_ctl = 2'b00;
      10'h0AB: token_ctl = 2'b01;
      10'h154: token_ctl = 2'b10;
      10'h2AB: token_ctl = 2'b11;
      default: is_token  = 1'b0;
    endcase
    q           = in_data[9] ? ~in_data[7:0] : in_data[7:0];
    data_dec    = 8'h00;
    data_dec[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      data_dec[i] = in_data[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_de   <= 1'b0;
      out_ctl  <= 2'b00;
      out_data <= 8'h00;
    end else if (is_token) begin
      out_de   <= 1'b0;
      out_ctl  <= token_ctl;
      out_data <= 8'h00;
    end else begin
      out_de   <= 1'b1;
      out_data <= data_dec;
    end
  end

  // Run counter is frozen at zero across a slip and its settle window.
  always_comb begin
    run_d = '0;
    if (state_q != StSlip && state_q != StWait && is_token) begin
      run_d = (run_q == RunMax) ? run_q : run_q + RunW'(1);
    end
  end

  // Fires once per run, on the token that brings the count to MIN_RUN.
  assign qualify = (state_q == StSearch || state_q == StLocked) && is_token &&
                   (run_q == RunLast);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TimerW'(1);
    unique case (state_q)
      StSearch: begin
        if (qualify) begin
          state_d = StLocked;
          timer_d = '0;
        end else if (timer_q == SearchLast) begin
          state_d = StSlip;
          timer_d = '0;
        end
      end
      StSlip: begin
        state_d = StWait;
        timer_d = '0;
      end
      StWait: begin
        if (timer_q == WaitLast) begin
          state_d = StSearch;
          timer_d = '0;
        end
      end
      StLocked: begin
        if (qualify) begin
          timer_d = '0;
        end else if (timer_q == LossLast) begin
          state_d = StSearch;
          timer_d = '0;
        end
      end
      default: begin
        state_d = StSearch;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StSearch;
      timer_q     <= '0;
      run_q       <= '0;
      out_bitslip <= 1'b0;
      out_locked  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      run_q       <= run_d;
      out_bitslip <= (state_d == StSlip);
      out_locked  <= (state_d == StLocked);
    end
  end

endmodule

// File: tb/tb_dvi_rx_tmds_decoder.sv
// Directed bench for dvi_rx_tmds_decoder with shortened timeouts, a reference TMDS
// encoder and a bitslip-aware deserializer model.
module tb_dvi_rx_tmds_decoder;

  localparam int unsigned MR = 8;
  localparam int unsigned ST = 64;
  localparam int unsigned BW = 16;
  localparam int unsigned LT = 256;

  logic       clk;
  logic       reset;
  logic [9:0] in_data;
  logic       out_bitslip;
  logic       out_locked;
  logic       out_de;
  logic [1:0] out_ctl;
  logic [7:0] out_data;

  int tests;
  int fails;
  int enc_cnt;

  dvi_rx_tmds_decoder #(
    .MIN_RUN       (MR),
    .SEARCH_TIMEOUT(ST),
    .BITSLIP_WAIT  (BW),
    .LOSS_TIMEOUT  (LT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .out_bitslip(out_bitslip),
    .out_locked (out_locked),
    .out_de     (out_de),
    .out_ctl    (out_ctl),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  // Outputs after step() reflect the word just applied.
  task automatic step(input logic [9:0] w);
    in_data = w;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(10'h000);
    step(10'h000);
    reset = 1'b0;
  endtask

  // Reference DVI transmit encoder with running disparity.
  task automatic encode(input logic [7:0] d, output logic [9:0] w);
    logic [8:0] qm;
    logic       use_xnor;
    int         n1d, n1q, n0q;
    n1d      = $countones(d);
    use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~use_xnor;
    n1q   = $countones(qm[7:0]);
    n0q   = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      w = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      enc_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
      w = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt += (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      w = {1'b0, qm[8], qm[7:0]};
      enc_cnt += n1q - n0q - (qm[8] ? 0 : 2);
    end
  endtask

  task automatic test_reset();
    int first;
    reset = 1'b1;
    step(10'h123);
    step(10'h354);
    step(10'h2AB);
    tests += 5;
    if (out_bitslip !== 1'b0) begin fails++; $display("FAIL reset_bitslip: got %b exp 0", out_bitslip); end
    if (out_locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b exp 0", out_locked); end
    if (out_de !== 1'b0) begin fails++; $display("FAIL reset_de: got %b exp 0", out_de); end
    if (out_ctl !== 2'b00) begin fails++; $display("FAIL reset_ctl: got %b exp 00", out_ctl); end
    if (out_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h exp 00", out_data); end
    reset = 1'b0;
    first = 0;
    for (int k = 1; k <= int'(ST) + 8; k++) begin
      step(10'h3FF);
      if (out_bitslip === 1'b1) begin first = k; break; end
    end
    tests++;
    if (first != int'(ST)) begin
      fails++; $display("FAIL first_slip: at cycle %0d exp %0d", first, ST);
    end
    first = 0;
    for (int k = 1; k <= int'(ST + BW) + 8; k++) begin
      step(10'h3FF);
      if (out_bitslip === 1'b1) begin first = k; break; end
    end
    tests++;
    if (first != int'(ST + BW) + 1) begin
      fails++; $display("FAIL second_slip: at cycle %0d exp %0d", first, ST + BW + 1);
    end
  endtask

  task automatic test_token_decode();
    logic [9:0] tok [4];
    logic [10:0] got;
    tok[0] = 10'h354; tok[1] = 10'h0AB; tok[2] = 10'h154; tok[3] = 10'h2AB;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(tok[i]);
      got = {out_de, out_ctl, out_data};
      tests++;
      if (got !== {1'b0, 2'(i), 8'h00}) begin
        fails++; $display("FAIL token_%0d: got de/ctl/data %h exp %h", i, got, {1'b0, 2'(i), 8'h00});
      end
    end
    step(10'h100);
    tests++;
    if (out_ctl !== 2'b11 || out_de !== 1'b1) begin
      fails++; $display("FAIL ctl_hold: got ctl %b de %b exp ctl 11 de 1", out_ctl, out_de);
    end
  endtask

  task automatic test_data_decode();
    logic [9:0] w;
    int errs;
    step(10'h100);
    tests++;
    if (out_de !== 1'b1 || out_data !== 8'h00) begin
      fails++; $display("FAIL data_100: got de %b data %h exp de 1 data 00", out_de, out_data);
    end
    step(10'h200);
    tests++;
    if (out_de !== 1'b1 || out_data !== 8'hFF) begin
      fails++; $display("FAIL data_200: got de %b data %h exp de 1 data ff", out_de, out_data);
    end
    step(10'h1FF);
    tests++;
    if (out_de !== 1'b1 || out_data !== 8'h01) begin
      fails++; $display("FAIL data_1ff: got de %b data %h exp de 1 data 01", out_de, out_data);
    end
    enc_cnt = 0;
    errs    = 0;
    for (int i = 0; i < 512; i++) begin
      encode(8'(i), w);
      step(w);
      if (out_de !== 1'b1 || out_data !== 8'(i)) errs++;
    end
    tests++;
    if (errs != 0) begin fails++; $display("FAIL data_sweep: %0d bad words exp 0", errs); end
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 0; i < 7; i++) step(10'h354);
    step(10'h100);
    step(10'h100);
    tests++;
    if (out_locked !== 1'b0) begin fails++; $display("FAIL lock_short_run: got %b exp 0", out_locked); end
    for (int i = 0; i < 7; i++) step(10'h354);
    tests++;
    if (out_locked !== 1'b0) begin fails++; $display("FAIL lock_7th: got %b exp 0", out_locked); end
    step(10'h354);
    tests++;
    if (out_locked !== 1'b1) begin fails++; $display("FAIL lock_8th: got %b exp 1", out_locked); end
  endtask

  task automatic test_loss();
    int early;
    for (int i = 0; i < int'(LT) - 1; i++) step(10'h100);
    tests++;
    if (out_locked !== 1'b1) begin fails++; $display("FAIL loss_early: got %b exp 1", out_locked); end
    step(10'h100);
    tests++;
    if (out_locked !== 1'b0) begin fails++; $display("FAIL loss_drop: got %b exp 0", out_locked); end
    early = 0;
    for (int i = 0; i < int'(ST) - 1; i++) begin
      step(10'h100);
      if (out_bitslip === 1'b1) early++;
    end
    tests++;
    if (early != 0) begin fails++; $display("FAIL loss_search_early: %0d pulses exp 0", early); end
    step(10'h100);
    tests++;
    if (out_bitslip !== 1'b1) begin fails++; $display("FAIL loss_search_slip: got %b exp 1", out_bitslip); end
  endtask

  task automatic test_reset_mid_op();
    int first;
    for (int i = 0; i < 4; i++) step(10'h100);
    reset = 1'b1;
    step(10'h100);
    tests++;
    if ({out_bitslip, out_locked, out_de} !== 3'b000) begin
      fails++; $display("FAIL reset_in_wait: got slip/lock/de %b exp 000", {out_bitslip, out_locked, out_de});
    end
    reset = 1'b0;
    first = 0;
    for (int k = 1; k <= int'(ST) + 8; k++) begin
      step(10'h100);
      if (out_bitslip === 1'b1) begin first = k; break; end
    end
    tests++;
    if (first != int'(ST)) begin
      fails++; $display("FAIL restart_slip: at cycle %0d exp %0d", first, ST);
    end
    reset = 1'b1;
    step(10'h100);
    reset = 1'b0;
    tests++;
    if (out_bitslip !== 1'b0) begin fails++; $display("FAIL reset_in_slip: got %b exp 0", out_bitslip); end
  endtask

  // Scaled-down frame: 40-word lines, 12 blanking tokens then 28 encoded bytes.
  task automatic test_alignment();
    logic [9:0]  prev_w, cur_w, rx;
    logic [19:0] win;
    logic        prev_de, cur_de;
    logic [7:0]  prev_b, cur_b;
    int off, slips, checked, errs, rx_off;
    do_reset();
    enc_cnt = 0;
    off = 7; slips = 0; checked = 0; errs = 0;
    prev_w = 10'h354; prev_de = 1'b0; prev_b = 8'h00;
    for (int n = 0; n < 1200; n++) begin
      if (n % 40 < 12) begin
        cur_w = 10'h354; cur_de = 1'b0; cur_b = 8'h00;
      end else begin
        cur_b = 8'(n * 7 + 3); cur_de = 1'b1;
        encode(cur_b, cur_w);
      end
      win    = {cur_w, prev_w};
      rx     = win[off +: 10];
      rx_off = off;
      step(rx);
      if (out_bitslip === 1'b1) begin
        slips++;
        off = (off + 1) % 10;
      end
      if (out_locked === 1'b1 && rx_off == 0) begin
        checked++;
        if (out_de !== prev_de || out_data !== prev_b || (!prev_de && out_ctl !== 2'b00)) errs++;
      end
      prev_w = cur_w; prev_de = cur_de; prev_b = cur_b;
    end
    tests++;
    if (slips != 3) begin fails++; $display("FAIL align_slips: got %0d exp 3", slips); end
    tests++;
    if (out_locked !== 1'b1) begin fails++; $display("FAIL align_locked: got %b exp 1", out_locked); end
    tests++;
    if (checked < 500) begin fails++; $display("FAIL align_coverage: %0d words checked exp >=500", checked); end
    tests++;
    if (errs != 0) begin fails++; $display("FAIL align_data: %0d bad words exp 0", errs); end
  endtask

  initial begin
    clk     = 1'b0;
    reset   = 1'b1;
    in_data = 10'h000;
    tests   = 0;
    fails   = 0;
    enc_cnt = 0;
    test_reset();
    test_token_decode();
    test_data_decode();
    test_lock();
    test_loss();
    test_reset_mid_op();
    test_alignment();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
